// File: rtl/clock_pkg.sv
// Shared clock-rate helpers for the tick generators and their benches.
package clock_pkg;

  // Rounded 2^acc_w * out_hz / sys_hz, carried out at 64 bits so ACC_W=32 cannot overflow.
  function automatic logic [63:0] calc_inc(input int unsigned sys_hz,
                                           input int unsigned out_hz,
                                           input int unsigned acc_w);
    logic [63:0] num;
    logic [63:0] den;
    num = 64'(out_hz) << acc_w;
    den = 64'(sys_hz);
    return (num + (den >> 1)) / den;
  endfunction

endpackage

// File: rtl/frac_step_sat.sv
// Increment plus signed trim, clamped to the unsigned ACC_W-bit range.
module frac_step_sat #(
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned TRIM_W = 8
) (
  input  logic [ACC_W-1:0]  inc,
  input  logic [TRIM_W-1:0] trim,
  output logic [ACC_W-1:0]  step
);

  // Two guard bits: bit ACC_W+1 is the sign, bit ACC_W flags overflow above 2^ACC_W-1.
  logic [ACC_W+1:0] sum;

  always_comb begin
    sum = {2'b00, inc} + {{(ACC_W+2-TRIM_W){trim[TRIM_W-1]}}, trim};
    if (sum[ACC_W+1]) begin
      step = '0;
    end else if (sum[ACC_W]) begin
      step = '1;
    end else begin
      step = sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/frac_tick_gen.sv
// Fractional NCO tick generator: programmable increment with wrap-aligned shadow
// update, signed trim, phase sync and a faster sub-tick.
module frac_tick_gen
  import clock_pkg::*;
#(
  parameter int unsigned SYS_CLK_HZ  = 50_000_000,
  parameter int unsigned OUT_CLK_HZ  = 1,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned TRIM_W      = 8,
  parameter int unsigned SUB_SHIFT   = 1,
  parameter logic [63:0] INC_DEFAULT = calc_inc(SYS_CLK_HZ, OUT_CLK_HZ, ACC_W)
) (
  input  logic              i_sysclk,
  input  logic              i_reset_n,
  input  logic              i_en,
  input  logic              i_sync,
  input  logic              i_inc_wr,
  input  logic [ACC_W-1:0]  i_inc,
  input  logic [TRIM_W-1:0] i_trim,
  output logic              o_div,
  output logic              o_tick,
  output logic              o_tick_sub,
  output logic              o_inc_pending,
  output logic [ACC_W-1:0]  o_inc_active
);

  localparam int unsigned   SUB_W   = ACC_W - SUB_SHIFT;
  localparam logic [ACC_W-1:0] INC_RST = INC_DEFAULT[ACC_W-1:0];

  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] inc_active_reg;
  logic [ACC_W-1:0] inc_shadow_reg;
  logic             pending_reg;
  logic             tick_reg;
  logic             tick_sub_reg;

  logic [ACC_W-1:0] step;
  logic [ACC_W:0]   sum_next;
  logic [SUB_W:0]   sub_sum_next;
  logic             carry;
  logic             carry_sub;

  frac_step_sat #(
    .ACC_W  (ACC_W),
    .TRIM_W (TRIM_W)
  ) u_step (
    .inc  (inc_active_reg),
    .trim (i_trim),
    .step (step)
  );

  // Carries, not MSB edges, mark wraps so a step near 2^ACC_W still ticks every add.
  always_comb begin
    sum_next     = {1'b0, acc_reg} + {1'b0, step};
    sub_sum_next = {1'b0, acc_reg[SUB_W-1:0]} + {1'b0, step[SUB_W-1:0]};
    carry        = sum_next[ACC_W];
    carry_sub    = sub_sum_next[SUB_W];
  end

  always_ff @(posedge i_sysclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc_reg        <= '0;
      inc_active_reg <= INC_RST;
      inc_shadow_reg <= INC_RST;
      pending_reg    <= 1'b0;
      tick_reg       <= 1'b0;
      tick_sub_reg   <= 1'b0;
    end else begin
      if (i_sync) begin
        acc_reg      <= '0;
        tick_reg     <= 1'b0;
        tick_sub_reg <= 1'b0;
        if (pending_reg) begin
          inc_active_reg <= inc_shadow_reg;
          pending_reg    <= 1'b0;
        end
      end else if (i_en) begin
        acc_reg      <= sum_next[ACC_W-1:0];
        tick_reg     <= carry;
        tick_sub_reg <= carry_sub;
        if (carry && pending_reg) begin
          inc_active_reg <= inc_shadow_reg;
          pending_reg    <= 1'b0;
        end
      end else begin
        tick_reg     <= 1'b0;
        tick_sub_reg <= 1'b0;
      end
      // A write on an apply edge overrides it, so it waits for the next wrap or sync.
      if (i_inc_wr) begin
        inc_shadow_reg <= i_inc;
        pending_reg    <= 1'b1;
      end
    end
  end

  assign o_div         = acc_reg[ACC_W-1];
  assign o_tick        = tick_reg;
  assign o_tick_sub    = tick_sub_reg;
  assign o_inc_pending = pending_reg;
  assign o_inc_active  = inc_active_reg;

endmodule

// File: tb/tb_frac_tick_gen.sv
// Scoreboard bench: stimulus queues expected o_tick cycles, a monitor pops on each tick.
module tb_frac_tick_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        sync = 1'b0;
  logic        inc_wr = 1'b0;
  logic [15:0] inc = '0;
  logic [7:0]  trim = '0;
  logic        o_div;
  logic        o_tick;
  logic        o_tick_sub;
  logic        o_inc_pending;
  logic [15:0] o_inc_active;

  int unsigned cyc = 0;
  int unsigned base;
  int unsigned nvec = 0;
  int unsigned nmis = 0;
  int unsigned exp_q[$];

  frac_tick_gen #(
    .SYS_CLK_HZ (1000),
    .OUT_CLK_HZ (1),
    .ACC_W      (16),
    .TRIM_W     (8),
    .SUB_SHIFT  (1)
  ) dut (
    .i_sysclk      (clk),
    .i_reset_n     (rst_n),
    .i_en          (en),
    .i_sync        (sync),
    .i_inc_wr      (inc_wr),
    .i_inc         (inc),
    .i_trim        (trim),
    .o_div         (o_div),
    .o_tick        (o_tick),
    .o_tick_sub    (o_tick_sub),
    .o_inc_pending (o_inc_pending),
    .o_inc_active  (o_inc_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    nvec++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end else begin
      $display("ok   %s cyc=%0d value=%0d", name, cyc, act);
    end
  endtask

  // Advance to #1 after the posedge that brings cyc to t.
  task automatic step_to(input int unsigned t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0; en = 1'b0; sync = 1'b0; inc_wr = 1'b0; inc = '0; trim = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && o_tick) begin
      nvec++;
      if (exp_q.size() == 0) begin
        nmis++;
        $display("FAIL tick_unexpected cyc=%0d actual=tick required=none", cyc);
      end else begin
        int unsigned e;
        e = exp_q.pop_front();
        if (e != cyc) begin
          nmis++;
          $display("FAIL tick_time actual_cyc=%0d required_cyc=%0d", cyc, e);
        end else begin
          $display("ok   tick cyc=%0d", cyc);
        end
      end
    end
  end

  initial begin
    // Reset state and nominal period (step 66)
    do_reset();
    check("rst_div", 32'(o_div), 0);
    check("rst_tick", 32'(o_tick), 0);
    check("rst_tick_sub", 32'(o_tick_sub), 0);
    check("rst_pending", 32'(o_inc_pending), 0);
    check("rst_active", 32'(o_inc_active), 66);
    en = 1'b1; base = cyc;
    exp_q.push_back(base + 993);
    exp_q.push_back(base + 1986);
    step_to(base + 496);
    check("s1_div_before", 32'(o_div), 0);
    check("s1_sub_before", 32'(o_tick_sub), 0);
    step_to(base + 497);
    check("s1_div_rise", 32'(o_div), 1);
    check("s1_sub_first", 32'(o_tick_sub), 1);
    step_to(base + 993);
    check("s1_sub_coincide", 32'(o_tick_sub), 1);
    step_to(base + 2000);

    // Shadow write mid-period, applied on first wrap
    do_reset();
    en = 1'b1; base = cyc;
    exp_q.push_back(base + 993);
    exp_q.push_back(base + 1494);
    exp_q.push_back(base + 1994);
    step_to(base + 300);
    inc_wr = 1'b1; inc = 16'd131;
    step_to(base + 301);
    inc_wr = 1'b0;
    check("s2_pending_set", 32'(o_inc_pending), 1);
    step_to(base + 992);
    check("s2_pending_hold", 32'(o_inc_pending), 1);
    check("s2_active_old", 32'(o_inc_active), 66);
    step_to(base + 993);
    check("s2_pending_clr", 32'(o_inc_pending), 0);
    check("s2_active_new", 32'(o_inc_active), 131);
    step_to(base + 2000);

    // Trim cancels increment: phase frozen
    do_reset();
    trim = 8'hBE;
    en = 1'b1; base = cyc;
    step_to(base + 2000);
    check("s3_frozen_div", 32'(o_div), 0);
    check("s3_frozen_active", 32'(o_inc_active), 66);

    // Saturated step: tick on every add after the first
    do_reset();
    inc_wr = 1'b1; inc = 16'hFFFF;
    step_to(cyc + 1);
    inc_wr = 1'b0; sync = 1'b1;
    step_to(cyc + 1);
    sync = 1'b0;
    check("s3_sat_active", 32'(o_inc_active), 65535);
    check("s3_sat_pending", 32'(o_inc_pending), 0);
    trim = 8'd5; en = 1'b1; base = cyc;
    for (int k = 2; k <= 20; k++) exp_q.push_back(base + k);
    step_to(base + 1);
    check("s3_sat_first_add", 32'(o_tick), 0);
    step_to(base + 20);
    en = 1'b0; trim = '0;
    step_to(cyc + 3);

    // Sync with a pending shadow
    do_reset();
    en = 1'b1; base = cyc;
    exp_q.push_back(base + 1202);
    exp_q.push_back(base + 1702);
    step_to(base + 300);
    inc_wr = 1'b1; inc = 16'd131;
    step_to(base + 301);
    inc_wr = 1'b0;
    step_to(base + 700);
    check("s4_div_presync", 32'(o_div), 1);
    sync = 1'b1;
    step_to(base + 701);
    sync = 1'b0;
    check("s4_sync_div", 32'(o_div), 0);
    check("s4_sync_tick", 32'(o_tick), 0);
    check("s4_sync_pending", 32'(o_inc_pending), 0);
    check("s4_sync_active", 32'(o_inc_active), 131);
    step_to(base + 1750);

    // Enable low for 100 cycles mid-period
    do_reset();
    en = 1'b1; base = cyc;
    exp_q.push_back(base + 1093);
    step_to(base + 600);
    en = 1'b0;
    step_to(base + 650);
    check("s5_div_held", 32'(o_div), 1);
    check("s5_tick_off", 32'(o_tick), 0);
    step_to(base + 700);
    en = 1'b1;
    step_to(base + 1100);

    // Asynchronous reset between edges
    do_reset();
    en = 1'b1; base = cyc;
    step_to(base + 600);
    inc_wr = 1'b1; inc = 16'd131;
    step_to(base + 601);
    inc_wr = 1'b0;
    check("s6_pending_pre", 32'(o_inc_pending), 1);
    step_to(base + 650);
    check("s6_div_pre", 32'(o_div), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("s6_async_div", 32'(o_div), 0);
    check("s6_async_tick", 32'(o_tick), 0);
    check("s6_async_sub", 32'(o_tick_sub), 0);
    check("s6_async_pending", 32'(o_inc_pending), 0);
    check("s6_async_active", 32'(o_inc_active), 66);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; en = 1'b1; base = cyc;
    exp_q.push_back(base + 993);
    step_to(base + 995);
    check("s6_active_after", 32'(o_inc_active), 66);

    step_to(cyc + 5);
    check("tick_queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
